wave_generator: RTL and testbench

Parametrised periodic waveform source for the components library, generalising the fixed 0..2^N-1 triangle counter. It adds programmable bounds, a programmable step, and selectable triangle, sawtooth-up, sawtooth-down and (optionally) square modes. It advances only on enabled cycles and flags every turnaround or wrap with a one-cycle event pulse. It feeds DAC/PWM test paths and is configured through a simple load strobe.

---
 rtl/wave_generator_if.sv | 24 ++
 rtl/wave_generator.sv | 138 +++++++++++++
 tb/tb_wave_generator.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/wave_generator_if.sv
// Bundles the wave_generator configuration/control inputs and waveform outputs.
interface wave_generator_if #(
    parameter int unsigned N = 8
);
    logic         ena;
    logic         load;
    logic [1:0]   cfg_mode;
    logic [N-1:0] cfg_lo;
    logic [N-1:0] cfg_hi;
    logic [N-1:0] cfg_step;
    logic [N-1:0] out;
    logic         dir;
    logic         evt;

    modport master (
        output ena, load, cfg_mode, cfg_lo, cfg_hi, cfg_step,
        input  out, dir, evt
    );

    modport slave (
        input  ena, load, cfg_mode, cfg_lo, cfg_hi, cfg_step,
        output out, dir, evt
    );
endinterface

// File: rtl/wave_generator.sv
// Programmable triangle / sawtooth / square waveform source with turnaround event pulse.
// Define WAVE_GEN_SQUARE_EN to enable square output in mode 3 (otherwise mode 3 = triangle).
module wave_generator #(
    parameter int unsigned N = 8
) (
    input logic            clk,
    input logic            rst,
    wave_generator_if.slave bus
);
    typedef enum logic [1:0] {
        ModeTri    = 2'd0,
        ModeSawUp  = 2'd1,
        ModeSawDn  = 2'd2,
        ModeSquare = 2'd3
    } mode_e;

    mode_e        mode_q, mode_d;
    logic [N-1:0] lo_q, lo_d;
    logic [N-1:0] hi_q, hi_d;
    logic [N-1:0] step_q, step_d;
    logic [N-1:0] acc_q, acc_d;
    logic         dir_q, dir_d;
    logic         evt_q, evt_d;

    logic [N-1:0] step_eff;
    logic [N:0]   sum;
    logic [N-1:0] up_sat;
    logic [N-1:0] dn_sat;
    logic         degenerate;

    // Saturating neighbours of acc, computed in N+1 bits so nothing wraps.
    always_comb begin
        step_eff   = (step_q == '0) ? {{(N-1){1'b0}}, 1'b1} : step_q;
        sum        = {1'b0, acc_q} + {1'b0, step_eff};
        up_sat     = (sum >= {1'b0, hi_q}) ? hi_q : sum[N-1:0];
        dn_sat     = ({1'b0, acc_q} <= ({1'b0, lo_q} + {1'b0, step_eff})) ? lo_q
                                                                           : acc_q - step_eff;
        degenerate = (lo_q >= hi_q);
    end

    always_comb begin
        mode_d = mode_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        step_d = step_q;
        acc_d  = acc_q;
        dir_d  = dir_q;
        evt_d  = 1'b0;
        if (bus.load) begin
            mode_d = mode_e'(bus.cfg_mode);
            lo_d   = bus.cfg_lo;
            hi_d   = bus.cfg_hi;
            step_d = bus.cfg_step;
            if (mode_e'(bus.cfg_mode) == ModeSawDn) begin
                acc_d = bus.cfg_hi;
                dir_d = 1'b0;
            end else begin
                acc_d = bus.cfg_lo;
                dir_d = 1'b1;
            end
        end else if (degenerate) begin
            acc_d = lo_q;
        end else if (bus.ena) begin
            case (mode_q)
                ModeSawUp: begin
                    dir_d = 1'b1;
                    if (acc_q == hi_q) begin
                        acc_d = lo_q;
                        evt_d = 1'b1;
                    end else begin
                        acc_d = up_sat;
                    end
                end
                ModeSawDn: begin
                    dir_d = 1'b0;
                    if (acc_q == lo_q) begin
                        acc_d = hi_q;
                        evt_d = 1'b1;
                    end else begin
                        acc_d = dn_sat;
                    end
                end
                default: begin
                    // Triangle; square shares the same acc/dir trajectory.
                    if (dir_q) begin
                        acc_d = up_sat;
                        if (up_sat == hi_q) begin
                            dir_d = 1'b0;
                            evt_d = 1'b1;
                        end
                    end else begin
                        acc_d = dn_sat;
                        if (dn_sat == lo_q) begin
                            dir_d = 1'b1;
                            evt_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= ModeTri;
            lo_q   <= '0;
            hi_q   <= '1;
            step_q <= {{(N-1){1'b0}}, 1'b1};
            acc_q  <= '0;
            dir_q  <= 1'b1;
            evt_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            step_q <= step_d;
            acc_q  <= acc_d;
            dir_q  <= dir_d;
            evt_q  <= evt_d;
        end
    end

    always_comb begin
        bus.dir = dir_q;
        bus.evt = evt_q;
`ifdef WAVE_GEN_SQUARE_EN
        if (degenerate) begin
            bus.out = lo_q;
        end else if (mode_q == ModeSquare) begin
            bus.out = dir_q ? hi_q : lo_q;
        end else begin
            bus.out = acc_q;
        end
`else
        bus.out = degenerate ? lo_q : acc_q;
`endif
    end
endmodule

// File: tb/tb_wave_generator.sv
// Directed, table-driven self-checking bench for wave_generator (N=4).
module tb_wave_generator;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst;

    wave_generator_if #(.N(N)) bus ();

    wave_generator #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ld;
        logic         ena;
        logic [1:0]   mode;
        logic [N-1:0] lo;
        logic [N-1:0] hi;
        logic [N-1:0] step;
        logic [N-1:0] exp_out;
        logic         exp_dir;
        logic         exp_evt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int o, input int d, input int e);
        chk({tag, ".out"}, int'(bus.out), o);
        chk({tag, ".dir"}, int'(bus.dir), d);
        chk({tag, ".evt"}, int'(bus.evt), e);
    endtask

    task automatic add(input logic ld, input logic ena, input int mode, input int lo,
                       input int hi, input int step, input int o, input int d, input int e);
        vec_t v;
        v.ld      = ld;
        v.ena     = ena;
        v.mode    = 2'(mode);
        v.lo      = N'(lo);
        v.hi      = N'(hi);
        v.step    = N'(step);
        v.exp_out = N'(o);
        v.exp_dir = d[0];
        v.exp_evt = e[0];
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_o, exp_d, exp_e;
        rst          = 1'b1;
        bus.ena      = 1'b0;
        bus.load     = 1'b0;
        bus.cfg_mode = 2'd0;
        bus.cfg_lo   = '0;
        bus.cfg_hi   = '0;
        bus.cfg_step = '0;
        tick();
        tick();
        chk_all("reset", 0, 1, 0);

        // Legacy full-range triangle: 1..15 then 14..0 then 1.
        rst     = 1'b0;
        bus.ena = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            exp_o = (i <= 15) ? i : ((i <= 30) ? 30 - i : 1);
            exp_d = (i >= 15 && i < 30) ? 0 : 1;
            exp_e = (i == 15 || i == 30) ? 1 : 0;
            chk_all($sformatf("legacy[%0d]", i), exp_o, exp_d, exp_e);
        end

        //  ld ena mode lo hi st   out dir evt
        add(1, 0, 0, 2, 9, 3,      2, 1, 0);
        add(0, 1, 0, 0, 0, 0,      5, 1, 0);
        add(0, 1, 0, 0, 0, 0,      8, 1, 0);
        add(0, 1, 0, 0, 0, 0,      9, 0, 1);
        add(0, 1, 0, 0, 0, 0,      6, 0, 0);
        add(0, 1, 0, 0, 0, 0,      3, 0, 0);
        add(0, 1, 0, 0, 0, 0,      2, 1, 1);
        add(0, 1, 0, 0, 0, 0,      5, 1, 0);
        // saw-up with an ena-low gap mid-ramp
        add(1, 0, 1, 0, 5, 2,      0, 1, 0);
        add(0, 1, 1, 0, 0, 0,      2, 1, 0);
        add(0, 0, 1, 0, 0, 0,      2, 1, 0);
        add(0, 0, 1, 0, 0, 0,      2, 1, 0);
        add(0, 0, 1, 0, 0, 0,      2, 1, 0);
        add(0, 1, 1, 0, 0, 0,      4, 1, 0);
        add(0, 1, 1, 0, 0, 0,      5, 1, 0);
        add(0, 1, 1, 0, 0, 0,      0, 1, 1);
        add(0, 1, 1, 0, 0, 0,      2, 1, 0);
        // saw-down
        add(1, 0, 2, 1, 8, 3,      8, 0, 0);
        add(0, 1, 2, 0, 0, 0,      5, 0, 0);
        add(0, 1, 2, 0, 0, 0,      2, 0, 0);
        add(0, 1, 2, 0, 0, 0,      1, 0, 0);
        add(0, 1, 2, 0, 0, 0,      8, 0, 1);
        // mode 3
`ifdef WAVE_GEN_SQUARE_EN
        add(1, 0, 3, 1, 6, 5,      6, 1, 0);
        add(0, 1, 3, 0, 0, 0,      1, 0, 1);
        add(0, 1, 3, 0, 0, 0,      6, 1, 1);
        add(0, 1, 3, 0, 0, 0,      1, 0, 1);
`else
        add(1, 0, 3, 1, 6, 5,      1, 1, 0);
        add(0, 1, 3, 0, 0, 0,      6, 0, 1);
        add(0, 1, 3, 0, 0, 0,      1, 1, 1);
        add(0, 1, 3, 0, 0, 0,      6, 0, 1);
`endif
        // step 0 behaves as step 1
        add(1, 0, 0, 3, 5, 0,      3, 1, 0);
        add(0, 1, 0, 0, 0, 0,      4, 1, 0);
        add(0, 1, 0, 0, 0, 0,      5, 0, 1);
        add(0, 1, 0, 0, 0, 0,      4, 0, 0);
        // saturation instead of modulo wrap at both ends
        add(1, 0, 0, 0, 15, 7,     0, 1, 0);
        add(0, 1, 0, 0, 0, 0,      7, 1, 0);
        add(0, 1, 0, 0, 0, 0,     14, 1, 0);
        add(0, 1, 0, 0, 0, 0,     15, 0, 1);
        add(0, 1, 0, 0, 0, 0,      8, 0, 0);
        add(0, 1, 0, 0, 0, 0,      1, 0, 0);
        add(0, 1, 0, 0, 0, 0,      0, 1, 1);
        // degenerate lo == hi
        add(1, 0, 0, 7, 7, 1,      7, 1, 0);
        add(0, 1, 0, 0, 0, 0,      7, 1, 0);
        add(0, 1, 0, 0, 0, 0,      7, 1, 0);
        // load with ena: load wins
        add(1, 1, 0, 4, 10, 2,     4, 1, 0);
        add(0, 1, 0, 0, 0, 0,      6, 1, 0);
        add(0, 1, 0, 0, 0, 0,      8, 1, 0);
        add(0, 1, 0, 0, 0, 0,     10, 0, 1);
        add(0, 0, 0, 0, 0, 0,     10, 0, 0);
        add(0, 1, 0, 0, 0, 0,      8, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.load     = vecs[i].ld;
            bus.ena      = vecs[i].ena;
            bus.cfg_mode = vecs[i].mode;
            bus.cfg_lo   = vecs[i].lo;
            bus.cfg_hi   = vecs[i].hi;
            bus.cfg_step = vecs[i].step;
            tick();
            chk_all($sformatf("vec[%0d]", i), int'(vecs[i].exp_out), int'(vecs[i].exp_dir),
                    int'(vecs[i].exp_evt));
        end

        // rst mid-descent beats a simultaneous load; config returns to full-range triangle
        rst          = 1'b1;
        bus.load     = 1'b1;
        bus.ena      = 1'b1;
        bus.cfg_mode = 2'd1;
        bus.cfg_lo   = 4'd3;
        bus.cfg_hi   = 4'd9;
        bus.cfg_step = 4'd2;
        tick();
        chk_all("rst_mid", 0, 1, 0);
        rst      = 1'b0;
        bus.load = 1'b0;
        tick();
        chk_all("post_rst1", 1, 1, 0);
        for (int i = 2; i <= 15; i++) tick();
        chk_all("post_rst15", 15, 0, 1);
        tick();
        chk_all("post_rst16", 14, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
